// File: rtl/prog_mem_pkg.sv
// Shared definitions for the loadable program memory: FSM states, default geometry and
// the instruction field layout used by assemblers and benches.
package prog_mem_pkg;

  localparam int unsigned DEF_INSTR_W = 29;
  localparam int unsigned DEF_ADDR_W  = 8;
  localparam logic [DEF_INSTR_W-1:0] DEF_NOP_WORD = '0;

  // Instruction layout: 5-bit opcode followed by three 8-bit operand fields.
  localparam int unsigned OPC_MSB = 28;
  localparam int unsigned OPC_LSB = 24;
  localparam int unsigned FA_MSB  = 23;
  localparam int unsigned FA_LSB  = 16;
  localparam int unsigned FB_MSB  = 15;
  localparam int unsigned FB_LSB  = 8;
  localparam int unsigned FC_MSB  = 7;
  localparam int unsigned FC_LSB  = 0;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StLoad
  } state_e;

  function automatic logic [DEF_INSTR_W-1:0] pack_instr(input logic [4:0] opc,
                                                        input logic [7:0] fa,
                                                        input logic [7:0] fb,
                                                        input logic [7:0] fc);
    return {opc, fa, fb, fc};
  endfunction

endpackage

// File: rtl/prog_mem_loader_if.sv
// Fetch port and host load stream of the program memory, bundled for the top-level ports.
interface prog_mem_loader_if import prog_mem_pkg::*; #(
  parameter int unsigned INSTR_W = DEF_INSTR_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) ();

  logic               in_fetch_req;
  logic [ADDR_W-1:0]  in_fetch_add;
  logic [INSTR_W-1:0] out_instruction;
  logic               out_instr_valid;

  logic               in_load_start;
  logic [ADDR_W-1:0]  in_load_base;
  logic [INSTR_W-1:0] in_load_data;
  logic               in_load_valid;
  logic               in_load_last;
  logic               out_load_ready;
  logic               out_load_done;
  logic               out_load_err;
  logic [ADDR_W:0]    out_load_count;
  logic               out_busy;

  // Host side: fetch stage plus loader.
  modport master (
    output in_fetch_req, in_fetch_add, in_load_start, in_load_base, in_load_data,
           in_load_valid, in_load_last,
    input  out_instruction, out_instr_valid, out_load_ready, out_load_done, out_load_err,
           out_load_count, out_busy
  );

  modport slave (
    input  in_fetch_req, in_fetch_add, in_load_start, in_load_base, in_load_data,
           in_load_valid, in_load_last,
    output out_instruction, out_instr_valid, out_load_ready, out_load_done, out_load_err,
           out_load_count, out_busy
  );

endinterface

// File: rtl/prog_mem_ram.sv
// Single-port synchronous RAM with write enable and a registered, read-enabled output.
module prog_mem_ram #(
  parameter int unsigned        DataW    = 29,
  parameter int unsigned        AddrW    = 8,
  parameter logic [DataW-1:0]   ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Output register holds its value between reads so the fetch result stays stable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= ResetVal;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem_loader.sv
// Run-time loadable program memory: self-clearing after reset, host-loaded over a
// valid/ready stream, read by the fetch stage with one cycle of latency.
module prog_mem_loader import prog_mem_pkg::*; #(
  parameter int unsigned        INSTR_W  = DEF_INSTR_W,
  parameter int unsigned        ADDR_W   = DEF_ADDR_W,
  parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(DEF_NOP_WORD)
) (
  input  logic             in_clk,
  input  logic             in_rst,
  prog_mem_loader_if.slave bus
);

  localparam int unsigned      DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  // Count value just before the beat that would exceed the memory.
  localparam logic [ADDR_W:0]   OVF_COUNT = (ADDR_W + 1)'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;

  logic                beat;
  logic                ram_we;
  logic                ram_re;
  logic [ADDR_W-1:0]   ram_addr;
  logic [INSTR_W-1:0]  ram_wdata;
  logic [INSTR_W-1:0]  ram_rdata;

  assign beat = (state_q == StLoad) && bus.in_load_valid;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= StClear;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear: if (ptr_q == LAST_ADDR) state_d = StIdle;
      StIdle:  if (bus.in_load_start) state_d = StLoad;
      StLoad:  if (beat && (bus.in_load_last || count_q == OVF_COUNT)) state_d = StIdle;
      default: state_d = StClear;
    endcase
  end

  // The single RAM port is shared: the pointer owns it while busy, fetch owns it in idle.
  always_comb begin
    ptr_d     = ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    done_d    = 1'b0;
    valid_d   = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = ptr_q;
    ram_wdata = NOP_WORD;
    unique case (state_q)
      StClear: begin
        ram_we = 1'b1;
        ptr_d  = ptr_q + ADDR_W'(1);
      end
      StIdle: begin
        ram_addr = bus.in_fetch_add;
        ram_re   = bus.in_fetch_req;
        valid_d  = bus.in_fetch_req;
        if (bus.in_load_start) begin
          ptr_d   = bus.in_load_base;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      StLoad: begin
        ram_wdata = bus.in_load_data;
        if (beat) begin
          ram_we  = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          count_d = count_q + (ADDR_W + 1)'(1);
          if (bus.in_load_last) begin
            done_d = 1'b1;
          end else if (count_q == OVF_COUNT) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  prog_mem_ram #(
    .DataW    (INSTR_W),
    .AddrW    (ADDR_W),
    .ResetVal (NOP_WORD)
  ) u_ram (
    .clk_i   (in_clk),
    .rst_i   (in_rst),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign bus.out_instruction = ram_rdata;
  assign bus.out_instr_valid = valid_q;
  assign bus.out_load_ready  = (state_q == StLoad);
  assign bus.out_load_done   = done_q;
  assign bus.out_load_err    = err_q;
  assign bus.out_load_count  = count_q;
  assign bus.out_busy        = (state_q != StIdle);

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: clear, load, wrap, overflow, concurrency, reset abort.
module tb_prog_mem_loader;
  import prog_mem_pkg::*;

  localparam int unsigned IW = 29;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  prog_mem_loader_if #(.INSTR_W(IW), .ADDR_W(AW)) bus ();

  prog_mem_loader #(
    .INSTR_W  (IW),
    .ADDR_W   (AW),
    .NOP_WORD ('0)
  ) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus)
  );

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    bus.in_fetch_req  = 1'b0;
    bus.in_fetch_add  = '0;
    bus.in_load_start = 1'b0;
    bus.in_load_base  = '0;
    bus.in_load_data  = '0;
    bus.in_load_valid = 1'b0;
    bus.in_load_last  = 1'b0;
  endtask

  // Counts busy cycles while hammering fetch and load_start, which must both be ignored.
  task automatic wait_clear(output int cycles, output int stray);
    cycles = 0;
    stray  = 0;
    bus.in_fetch_req  = 1'b1;
    bus.in_fetch_add  = 8'h00;
    bus.in_load_start = 1'b1;
    bus.in_load_base  = 8'h33;
    while (bus.out_busy === 1'b1 && cycles < 1000) begin
      if (bus.out_instr_valid !== 1'b0 || bus.out_load_done !== 1'b0 ||
          bus.out_load_ready !== 1'b0) stray++;
      cycles++;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic do_fetch(input logic [AW-1:0] a);
    bus.in_fetch_req = 1'b1;
    bus.in_fetch_add = a;
    @(negedge clk);
    bus.in_fetch_req = 1'b0;
  endtask

  task automatic start_load(input logic [AW-1:0] base);
    bus.in_load_start = 1'b1;
    bus.in_load_base  = base;
    @(negedge clk);
    bus.in_load_start = 1'b0;
  endtask

  task automatic beat(input logic [IW-1:0] d, input logic last);
    bus.in_load_valid = 1'b1;
    bus.in_load_data  = d;
    bus.in_load_last  = last;
    @(negedge clk);
    bus.in_load_valid = 1'b0;
    bus.in_load_last  = 1'b0;
  endtask

  task automatic test_reset();
    int cyc, stray;
    logic [AW-1:0] addrs [3];
    addrs = '{8'd0, 8'd1, 8'd255};
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (bus.out_busy !== 1'b1 || bus.out_load_ready !== 1'b0 || bus.out_load_done !== 1'b0 ||
        bus.out_load_err !== 1'b0 || bus.out_load_count !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_flags: busy=%b ready=%b done=%b err=%b count=%0d want 1/0/0/0/0",
               bus.out_busy, bus.out_load_ready, bus.out_load_done, bus.out_load_err,
               bus.out_load_count);
    end
    n_cmp++;
    if (bus.out_instruction !== 29'h0 || bus.out_instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_fetch: instr=%h valid=%b want 0/0",
               bus.out_instruction, bus.out_instr_valid);
    end
    wait_clear(cyc, stray);
    n_cmp++;
    if (cyc != 256) begin
      n_bad++;
      $display("FAIL clear_len: busy cycles=%0d want 256", cyc);
    end
    n_cmp++;
    if (stray != 0) begin
      n_bad++;
      $display("FAIL clear_ignore: stray outputs in %0d cycles want 0", stray);
    end
    for (int i = 0; i < 3; i++) begin
      do_fetch(addrs[i]);
      n_cmp++;
      if (bus.out_instr_valid !== 1'b1 || bus.out_instruction !== 29'h0) begin
        n_bad++;
        $display("FAIL clear_fetch[%0d]: valid=%b instr=%h want 1/0", addrs[i],
                 bus.out_instr_valid, bus.out_instruction);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.out_instr_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL valid_pulse[%0d]: valid=%b want 0", addrs[i], bus.out_instr_valid);
      end
    end
  endtask

  task automatic test_load();
    logic [IW-1:0] w [4];
    w = '{pack_instr(5'h0A, 8'h08, 8'h04, 8'h01), 29'h02020501, 29'h05030208, 29'h06040302};
    start_load(8'd1);
    n_cmp++;
    if (bus.out_load_ready !== 1'b1 || bus.out_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL load_enter: ready=%b busy=%b want 1/1", bus.out_load_ready, bus.out_busy);
    end
    for (int i = 0; i < 4; i++) begin
      beat(w[i], i == 3);
      n_cmp++;
      if (bus.out_load_done !== (i == 3)) begin
        n_bad++;
        $display("FAIL load_done_beat%0d: done=%b want %0b", i, bus.out_load_done, i == 3);
      end
    end
    n_cmp++;
    if (bus.out_load_count !== 9'd4 || bus.out_busy !== 1'b0 || bus.out_load_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL load_end: count=%0d busy=%b ready=%b want 4/0/0", bus.out_load_count,
               bus.out_busy, bus.out_load_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out_load_done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_pulse: done=%b want 0", bus.out_load_done);
    end
    bus.in_fetch_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_fetch_add = 8'(i + 1);
      @(negedge clk);
      n_cmp++;
      if (bus.out_instr_valid !== 1'b1 || bus.out_instruction !== w[i]) begin
        n_bad++;
        $display("FAIL b2b_fetch[%0d]: valid=%b instr=%h want 1/%h", i + 1,
                 bus.out_instr_valid, bus.out_instruction, w[i]);
      end
    end
    bus.in_fetch_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.out_instr_valid !== 1'b0 || bus.out_instruction !== w[3]) begin
      n_bad++;
      $display("FAIL fetch_hold: valid=%b instr=%h want 0/%h", bus.out_instr_valid,
               bus.out_instruction, w[3]);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a   [5];
    logic [IW-1:0] exp [5];
    start_load(8'd254);
    beat(29'h01110001, 1'b0);
    beat(29'h02220002, 1'b0);
    beat(29'h03330003, 1'b1);
    n_cmp++;
    if (bus.out_load_count !== 9'd3 || bus.out_load_done !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_end: count=%0d done=%b want 3/1", bus.out_load_count,
               bus.out_load_done);
    end
    a   = '{8'd0, 8'd254, 8'd255, 8'd253, 8'd1};
    exp = '{29'h03330003, 29'h01110001, 29'h02220002, 29'h0, 29'h0A080401};
    for (int i = 0; i < 5; i++) begin
      do_fetch(a[i]);
      n_cmp++;
      if (bus.out_instruction !== exp[i] || bus.out_instr_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL wrap_fetch[%0d]: instr=%h valid=%b want %h/1", a[i],
                 bus.out_instruction, bus.out_instr_valid, exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int not_ready = 0;
    start_load(8'd0);
    for (int i = 0; i < 256; i++) begin
      if (bus.out_load_ready !== 1'b1) not_ready++;
      if (i == 255) begin
        n_cmp++;
        if (bus.out_load_err !== 1'b0 || bus.out_load_done !== 1'b0 ||
            bus.out_load_count !== 9'd255) begin
          n_bad++;
          $display("FAIL ovf_pre: err=%b done=%b count=%0d want 0/0/255", bus.out_load_err,
                   bus.out_load_done, bus.out_load_count);
        end
      end
      beat(29'h01000000 | 29'(i), 1'b0);
    end
    n_cmp++;
    if (not_ready != 0) begin
      n_bad++;
      $display("FAIL ovf_ready: ready low on %0d beats want 0", not_ready);
    end
    n_cmp++;
    if (bus.out_load_err !== 1'b1 || bus.out_load_done !== 1'b1 || bus.out_load_ready !== 1'b0 ||
        bus.out_load_count !== 9'd256) begin
      n_bad++;
      $display("FAIL ovf_end: err=%b done=%b ready=%b count=%0d want 1/1/0/256",
               bus.out_load_err, bus.out_load_done, bus.out_load_ready, bus.out_load_count);
    end
    bus.in_load_valid = 1'b1;
    bus.in_load_data  = 29'h1FFFFFFF;
    @(negedge clk);
    bus.in_load_valid = 1'b0;
    n_cmp++;
    if (bus.out_load_err !== 1'b1 || bus.out_load_done !== 1'b0 ||
        bus.out_load_count !== 9'd256) begin
      n_bad++;
      $display("FAIL ovf_sticky: err=%b done=%b count=%0d want 1/0/256", bus.out_load_err,
               bus.out_load_done, bus.out_load_count);
    end
    do_fetch(8'h00);
    n_cmp++;
    if (bus.out_instruction !== 29'h01000000) begin
      n_bad++;
      $display("FAIL ovf_fetch0: instr=%h want 01000000", bus.out_instruction);
    end
    do_fetch(8'hFF);
    n_cmp++;
    if (bus.out_instruction !== 29'h010000FF) begin
      n_bad++;
      $display("FAIL ovf_fetchff: instr=%h want 010000ff", bus.out_instruction);
    end
  endtask

  task automatic test_concurrent();
    logic [AW-1:0] a   [4];
    logic [IW-1:0] exp [4];
    bus.in_fetch_req  = 1'b1;
    bus.in_fetch_add  = 8'h10;
    bus.in_load_start = 1'b1;
    bus.in_load_base  = 8'h10;
    @(negedge clk);
    bus.in_load_start = 1'b0;
    n_cmp++;
    if (bus.out_instr_valid !== 1'b1 || bus.out_instruction !== 29'h01000010) begin
      n_bad++;
      $display("FAIL conc_fetch: valid=%b instr=%h want 1/01000010", bus.out_instr_valid,
               bus.out_instruction);
    end
    n_cmp++;
    if (bus.out_load_err !== 1'b0 || bus.out_load_ready !== 1'b1 ||
        bus.out_load_count !== 9'd0) begin
      n_bad++;
      $display("FAIL conc_start: err=%b ready=%b count=%0d want 0/1/0", bus.out_load_err,
               bus.out_load_ready, bus.out_load_count);
    end
    bus.in_fetch_add = 8'h20;
    @(negedge clk);
    n_cmp++;
    if (bus.out_instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL load_fetch_blocked: valid=%b want 0", bus.out_instr_valid);
    end
    bus.in_fetch_req = 1'b0;
    beat(29'h1ABCDEF0, 1'b0);
    bus.in_load_data  = 29'h0BADBAD0;
    bus.in_load_start = 1'b1;
    bus.in_load_base  = 8'h50;
    repeat (3) @(negedge clk);
    bus.in_load_start = 1'b0;
    n_cmp++;
    if (bus.out_load_count !== 9'd1 || bus.out_load_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL stall: count=%0d ready=%b want 1/1", bus.out_load_count,
               bus.out_load_ready);
    end
    beat(29'h12345678, 1'b1);
    n_cmp++;
    if (bus.out_load_count !== 9'd2 || bus.out_load_done !== 1'b1) begin
      n_bad++;
      $display("FAIL conc_end: count=%0d done=%b want 2/1", bus.out_load_count,
               bus.out_load_done);
    end
    a   = '{8'h10, 8'h11, 8'h12, 8'h50};
    exp = '{29'h1ABCDEF0, 29'h12345678, 29'h01000012, 29'h01000050};
    for (int i = 0; i < 4; i++) begin
      do_fetch(a[i]);
      n_cmp++;
      if (bus.out_instruction !== exp[i]) begin
        n_bad++;
        $display("FAIL conc_fetch[%0h]: instr=%h want %h", a[i], bus.out_instruction, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int cyc, stray;
    logic [AW-1:0] a [4];
    start_load(8'h40);
    beat(29'h11111111, 1'b0);
    beat(29'h02222222, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (bus.out_load_done !== 1'b0 || bus.out_busy !== 1'b1 || bus.out_load_count !== 9'd0 ||
        bus.out_load_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL abort: done=%b busy=%b count=%0d ready=%b want 0/1/0/0",
               bus.out_load_done, bus.out_busy, bus.out_load_count, bus.out_load_ready);
    end
    wait_clear(cyc, stray);
    n_cmp++;
    if (cyc != 256 || stray != 0) begin
      n_bad++;
      $display("FAIL reclear: cycles=%0d stray=%0d want 256/0", cyc, stray);
    end
    a = '{8'h40, 8'h41, 8'h10, 8'h80};
    for (int i = 0; i < 4; i++) begin
      do_fetch(a[i]);
      n_cmp++;
      if (bus.out_instruction !== 29'h0 || bus.out_instr_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL reclear_fetch[%0h]: instr=%h valid=%b want 0/1", a[i],
                 bus.out_instruction, bus.out_instr_valid);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load();
    test_wrap();
    test_overflow();
    test_concurrent();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
Parametrised, synchronous program memory for the microprocessor. It replaces the hard-coded initial-block instruction ROM with a RAM that a host loads at run time over a valid/ready stream. After reset the block zero-fills itself, so every location holds instruction 0 (NOP). The fetch stage reads it with one-cycle registered latency, and fetch is blocked while the clear or load sequence runs.

Parameters:
INSTR_W, 29, instruction width (5-bit opcode + three 8-bit fields)
ADDR_W, 8, address width; depth is a derived constant DEPTH = 2**ADDR_W
NOP_WORD, 0, value written by the clear sequence and driven on out_instruction at reset

Ports:
in_clk  input  1  clock; all logic on the rising edge
in_rst  input  1  synchronous reset, active-high
in_fetch_req  input  1  fetch request, honoured only when out_busy=0
in_fetch_add  input  ADDR_W  fetch address
out_instruction  output  INSTR_W  registered fetched instruction
out_instr_valid  output  1  one-cycle pulse: out_instruction updated this cycle
in_load_start  input  1  pulse; begins a load at in_load_base
in_load_base  input  ADDR_W  first write address, sampled with in_load_start
in_load_data  input  INSTR_W  instruction word to write
in_load_valid  input  1  host has a word
in_load_last  input  1  marks the final word, qualified by in_load_valid
out_load_ready  output  1  block accepts a word this cycle
out_load_done  output  1  one-cycle pulse when a load ends
out_load_err  output  1  sticky overflow flag; cleared by the next accepted in_load_start or by reset
out_load_count  output  ADDR_W+1  words written by the current or last load
out_busy  output  1  high in the CLEAR and LOAD states

Behaviour:
- Reset (in_rst=1 at an edge) sets the following:
  - state=CLEAR, clear pointer=0.
  - out_instruction=NOP_WORD, out_instr_valid=0.
  - out_load_ready=0, out_load_done=0, out_load_err=0, out_load_count=0.
  - out_busy=1 from the first post-reset cycle.
- Reset mid-load aborts the load: no done pulse is issued and the memory is zero-filled again.
- CLEAR state:
  - Writes NOP_WORD to mem[ptr] each cycle and increments ptr.
  - After writing DEPTH-1, moves to IDLE. CLEAR therefore lasts exactly DEPTH cycles.
  - in_load_start and in_fetch_req are ignored while in CLEAR.
- IDLE state, fetch:
  - If in_fetch_req=1 at edge N, then at edge N+1: out_instruction=mem[in_fetch_add sampled at N] and out_instr_valid=1.
  - Without a request, out_instr_valid=0 and out_instruction holds its last value.
  - Back-to-back requests give one result per cycle.
- IDLE state, load start:
  - in_load_start=1 sets ptr=in_load_base, out_load_count=0, out_load_err=0, and moves to LOAD.
  - A fetch in the same cycle as in_load_start is still served and returns pre-load data.
- LOAD state:
  - out_load_ready=1 and out_busy=1. in_fetch_req is ignored (out_instr_valid stays 0). in_load_start is ignored.
  - A beat is in_load_valid & out_load_ready at an edge. Each beat writes mem[ptr]=in_load_data, sets ptr=(ptr+1) mod DEPTH (wrap 255→0 permitted), and increments out_load_count.
  - A beat with in_load_last=1: return to IDLE and pulse out_load_done in the following cycle.
  - Overflow: the DEPTH-th beat without last → return to IDLE, out_load_err=1, out_load_done pulses. Further host words are not accepted (ready=0).
  - Valid low: no write and no state change. The host may stall indefinitely.
- Memory contents persist across loads. Only reset clears them.
- Write and read are never simultaneous, so there is no read-during-write case.

Decomposition:
- Shared package prog_mem_pkg holds:
  - the state enum (CLEAR, IDLE, LOAD);
  - INSTR_W and ADDR_W defaults;
  - NOP_WORD;
  - opcode field positions [28:24], [23:16], [15:8], [7:0] for benches and assemblers.
- One natural sub-module, prog_mem_ram: a single-port synchronous RAM with write enable and a registered read. The FSM and loader live in the top.

Test Plan:
1. Reset, wait → out_busy high exactly 256 cycles. Then fetching addresses 0, 1 and 255 each returns 0 with a one-cycle valid pulse.
2. Load from base 1 with words 0x0A080401, 0x02020501, 0x05030208, 0x06040302, last on word 4 → out_load_done one cycle after the last beat, out_load_count=4. Fetch 1..4 returns those words back-to-back, one per cycle.
3. Load 3 words from base 254 → writes land at 254, 255 and 0. Fetch 0 returns the third word. Fetch 253 returns 0.
4. Stream 256 words, none with last → out_load_err=1, out_load_done pulses, out_load_ready drops, out_load_count=256. The next load_start clears out_load_err.
5. Assert in_fetch_req and in_load_start in the same IDLE cycle → old data returned with valid. Fetches during LOAD produce no valid. Toggle in_load_valid low mid-load → no extra writes.
6. Reset after 2 of 5 load beats → no done pulse, CLEAR repeats for 256 cycles, and the previously written addresses read 0.
